// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduling slice: state encoding and the
// byte/baud constants used by both the scheduler and the datapath.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int CLKS_PER_BIT = 521;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr (wrapping),
// or the locked owner alone when a packet holds the channel.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [REQ_W-1:0]   ptr_i,
    input  logic               lock_i,
    input  logic [REQ_W-1:0]   lock_id_i,
    output logic [REQ_W-1:0]   pick_o,
    output logic               any_valid_o
);

    localparam logic [REQ_W:0] NUM_REQ_W = (REQ_W + 1)'(NUM_REQ);

    always_comb begin
        logic [REQ_W:0] idx;
        pick_o      = '0;
        any_valid_o = 1'b0;
        idx         = '0;
        if (lock_i) begin
            pick_o      = lock_id_i;
            any_valid_o = req_i[lock_id_i];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // ptr and k are both below NUM_REQ, so one subtraction wraps the sum.
                idx = {1'b0, ptr_i} + (REQ_W + 1)'(k);
                if (idx >= NUM_REQ_W) begin
                    idx = idx - NUM_REQ_W;
                end
                if (!any_valid_o && req_i[idx[REQ_W-1:0]]) begin
                    pick_o      = idx[REQ_W-1:0];
                    any_valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ byte producers with round-robin
// arbitration and packet locking; tracks tx_busy until each frame completes.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int REQ_W        = 2,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic                           grant_valid,
    output logic [REQ_W-1:0]               grant_id,
    output logic                           tx_timeout,
    output state_t                         dbg_state
);

    localparam int               CNT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [REQ_W-1:0] ID_LAST  = REQ_W'(NUM_REQ - 1);

    state_t                   state_q, state_d;
    logic [UART_DATA_W-1:0]   data_q, data_d;
    logic [REQ_W-1:0]         gid_q, gid_d;
    logic                     gvalid_q, gvalid_d;
    logic                     lock_q, lock_d;
    logic [REQ_W-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [REQ_W-1:0]         pick;
    logic                     any_valid;
    logic [UART_DATA_W-1:0]   sel_data;
    logic [REQ_W-1:0]         ptr_after_owner;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .lock_i      (lock_q),
        .lock_id_i   (gid_q),
        .pick_o      (pick),
        .any_valid_o (any_valid)
    );

    assign sel_data        = req_data[{pick, 3'b000} +: UART_DATA_W];
    assign ptr_after_owner = (gid_q == ID_LAST) ? '0 : gid_q + 1'b1;

    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign grant_valid = gvalid_q;
    assign dbg_state   = state_q;

    // Handshake: a byte moves on the edge where req_valid[i] & req_ready[i];
    // ready is raised only in IDLE, only for the picked index, and only when it is valid.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        gid_d      = gid_q;
        gvalid_d   = gvalid_q;
        lock_d     = lock_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        tx_start   = 1'b0;
        tx_timeout = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    req_ready[pick] = 1'b1;
                    data_d          = sel_data;
                    gid_d           = pick;
                    gvalid_d        = 1'b1;
                    lock_d          = ~req_last[pick];
                    state_d         = ST_START;
                end
            end
            ST_START: begin
                tx_start = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never took the byte: abort the packet and move on.
                    tx_timeout = 1'b1;
                    lock_d     = 1'b0;
                    gvalid_d   = 1'b0;
                    ptr_d      = ptr_after_owner;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                    if (!lock_q) begin
                        gvalid_d = 1'b0;
                        ptr_d    = ptr_after_owner;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            req_ready  = '0;
            tx_start   = 1'b0;
            tx_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            gid_q    <= '0;
            gvalid_q <= 1'b0;
            lock_q   <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            gvalid_q <= gvalid_d;
            lock_q   <= lock_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: per-requester byte queues drive the inputs,
// a transmitter model answers tx_start, and a monitor checks each frame in order.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int REQ_W        = 2;
    localparam int BUSY_TIMEOUT = 64;
    localparam int BIT_CLKS     = 4;
    localparam int FRAME_CLKS   = 10 * BIT_CLKS;
    localparam int EW           = REQ_W + 8;

    localparam int W_START   = 0;
    localparam int W_BUSY_HI = 1;
    localparam int W_BUSY_LO = 2;
    localparam int W_TIMEOUT = 3;
    localparam int W_IDLE    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [REQ_W-1:0]     grant_id;
    logic                 tx_timeout;
    state_t               dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pushed = 0;
    int n_to = 0;
    int last_acc_cyc = 0;
    bit busy_en;
    int busy_delay;

    logic [EW-1:0] exp_q[$];
    logic [8:0]    rq[NUM_REQ][$];

    uart_tx_sched #(
        .NUM_REQ      (NUM_REQ),
        .REQ_W        (REQ_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .tx_timeout  (tx_timeout),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_req(input int id, input bit last, input logic [7:0] d);
        rq[id].push_back({last, d});
        n_pushed++;
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_q.push_back({REQ_W'(id), d});
    endtask

    function automatic bit wait_cond(input int which);
        bit all_empty;
        all_empty = (exp_q.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) all_empty = 1'b0;
        case (which)
            W_START:   return tx_start;
            W_BUSY_HI: return tx_busy;
            W_BUSY_LO: return !tx_busy;
            W_TIMEOUT: return tx_timeout;
            default:   return all_empty && dbg_state == ST_IDLE && !tx_busy && !tx_start;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!wait_cond(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!wait_cond(which)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: condition not reached, waited %0d cycles, required within %0d", name, n, budget);
        end
    endtask

    // Requester model: valid while its queue holds bytes; front pops once accepted.
    initial begin
        logic [NUM_REQ-1:0] acc;
        logic [8:0]         tmp;
        acc       = '0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && rq[i].size() > 0) tmp = rq[i].pop_front();
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) begin
                    tmp              = rq[i][0];
                    req_data[i*8+:8] = tmp[7:0];
                    req_last[i]      = tmp[8];
                end else begin
                    req_data[i*8+:8] = 8'h00;
                    req_last[i]      = 1'b0;
                end
            end
            #1;
            acc = req_ready & req_valid;
            if (req_ready != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                check("ready_only_when_valid", req_ready & ~req_valid, 0);
                n_acc++;
                last_acc_cyc = cyc;
            end
        end
    end

    // Transmitter model: busy rises busy_delay cycles after tx_start, for one frame.
    initial begin
        int bcnt;
        int dcnt;
        bcnt    = 0;
        dcnt    = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_busy = 1'b0;
                bcnt    = 0;
                dcnt    = 0;
            end else begin
                if (tx_busy) begin
                    bcnt--;
                    if (bcnt == 0) tx_busy = 1'b0;
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        tx_busy = 1'b1;
                        bcnt    = FRAME_CLKS;
                    end
                end
                if (tx_start && busy_en) begin
                    if (busy_delay == 0) begin
                        tx_busy = 1'b1;
                        bcnt    = FRAME_CLKS;
                    end else begin
                        dcnt = busy_delay;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        int            start_cyc;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                check("start_latency", cyc, last_acc_cyc + 1);
                check("grant_valid_at_start", grant_valid, 1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: got tx_data 0x%0h id %0d, expected no frame", tx_data, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e[7:0]);
                    check("grant_id", grant_id, e[EW-1:8]);
                end
                start_cyc = cyc;
            end
            if (!rst && tx_timeout) begin
                n_to++;
                check("timeout_latency", cyc - start_cyc, BUSY_TIMEOUT);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b1;
        busy_en    = 1'b1;
        busy_delay = 0;
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_tx_timeout", tx_timeout, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;

        // Single byte from requester 0; afterwards ptr=1, then req3 brings ptr back to 0.
        push_req(0, 1'b1, 8'h55); push_exp(0, 8'h55);
        wait_for("t1_idle", W_IDLE, 300);
        push_req(3, 1'b1, 8'h33); push_exp(3, 8'h33);
        wait_for("t1b_idle", W_IDLE, 300);

        // All four valid at once: 0,1,2,3 then requester 0's second byte.
        busy_delay = 2;
        push_req(0, 1'b1, 8'hA0); push_req(0, 1'b1, 8'hB0);
        push_req(1, 1'b1, 8'hA1); push_req(2, 1'b1, 8'hA2); push_req(3, 1'b1, 8'hA3);
        push_exp(0, 8'hA0); push_exp(1, 8'hA1); push_exp(2, 8'hA2);
        push_exp(3, 8'hA3); push_exp(0, 8'hB0);
        wait_for("t2_idle", W_IDLE, 800);
        busy_delay = 0;

        // Lock: requester 0 keeps the channel for 3 bytes although requester 1 waits.
        push_exp(0, 8'hC0); push_exp(0, 8'hC1); push_exp(0, 8'hC2); push_exp(1, 8'hD1);
        push_req(0, 1'b0, 8'hC0);
        wait_for("t3_start0", W_START, 50);
        push_req(1, 1'b1, 8'hD1);
        wait_for("t3_busy_lo", W_BUSY_LO, 200);
        repeat (5) @(negedge clk);
        check("t3_gap_ready", req_ready, 0);
        check("t3_gap_grant_valid", grant_valid, 1);
        check("t3_gap_grant_id", grant_id, 0);
        check("t3_gap_state", dbg_state, ST_IDLE);
        push_req(0, 1'b0, 8'hC1);
        wait_for("t3_start1", W_START, 50);
        push_req(0, 1'b1, 8'hC2);
        wait_for("t3_idle", W_IDLE, 400);

        // Wrap: ptr=3 after req2, then 1001 grants 3 then 0; 0011 then grants 1 first.
        push_req(2, 1'b1, 8'h22); push_exp(2, 8'h22);
        wait_for("t4a_idle", W_IDLE, 300);
        push_req(0, 1'b1, 8'hE0); push_req(3, 1'b1, 8'hE3);
        push_exp(3, 8'hE3); push_exp(0, 8'hE0);
        wait_for("t4b_idle", W_IDLE, 400);
        push_req(0, 1'b1, 8'hF0); push_req(1, 1'b1, 8'hF1);
        push_exp(1, 8'hF1); push_exp(0, 8'hF0);
        wait_for("t4c_idle", W_IDLE, 400);

        // Timeout: busy never rises for a locked packet; the next requester is served.
        busy_en = 1'b0;
        push_req(2, 1'b0, 8'h5A); push_exp(2, 8'h5A); push_exp(3, 8'h6B);
        wait_for("t5_start", W_START, 50);
        push_req(3, 1'b1, 8'h6B);
        wait_for("t5_timeout", W_TIMEOUT, BUSY_TIMEOUT + 20);
        busy_en = 1'b1;
        @(negedge clk);
        check("t5_grant_valid_cleared", grant_valid, 0);
        check("t5_tx_data_held", tx_data, 8'h5A);
        check("t5_grant_id_held", grant_id, 2);
        wait_for("t5_idle", W_IDLE, 300);

        // Reset during WAIT_DONE with requester 2 pending behind a lock.
        push_req(1, 1'b0, 8'h77); push_exp(1, 8'h77); push_exp(2, 8'h88);
        wait_for("t6_start", W_START, 50);
        wait_for("t6_busy_hi", W_BUSY_HI, 20);
        repeat (3) @(negedge clk);
        push_req(2, 1'b1, 8'h88);
        repeat (2) @(negedge clk);
        check("t6_pre_state", dbg_state, ST_WAIT_DONE);
        check("t6_locked_out", req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_state", dbg_state, ST_IDLE);
        check("t6_rst_tx_start", tx_start, 0);
        check("t6_rst_tx_data", tx_data, 0);
        check("t6_rst_grant_valid", grant_valid, 0);
        check("t6_rst_grant_id", grant_id, 0);
        check("t6_rst_tx_timeout", tx_timeout, 0);
        check("t6_rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_for("t6_idle", W_IDLE, 300);

        // ---------------- final report ----------------
        check("accept_count", n_acc, n_pushed);
        check("exp_q_drained", exp_q.size(), 0);
        check("timeout_pulse_cycles", n_to, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Accepts bytes over a valid/ready handshake.
- Drives a one-cycle start pulse and stable data to the transmitter, then tracks the transmitter's busy flag until the frame completes.
- Supports multi-byte packets: once a requester is granted, it keeps the grant until it sends a byte flagged last.
- Sits between the application requesters and the UART TX datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_W, 2, grant index width, equal to clog2(NUM_REQ).
- BUSY_TIMEOUT, 64, cycles to wait for tx_busy to rise after tx_start before aborting.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous and active-high.
- req_valid  input  NUM_REQ  requester i has a byte available.
- req_data  input  NUM_REQ*8  byte of requester i in bits [8i+7:8i].
- req_last  input  NUM_REQ  the byte of requester i ends its packet.
- req_ready  output  NUM_REQ  one-hot; the byte of requester i is accepted this cycle.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte to transmit; held stable from tx_start until the frame ends.
- tx_busy  input  1  transmitter is sending a frame.
- grant_valid  output  1  a requester currently owns the channel.
- grant_id  output  REQ_W  index of the current or last owner.
- tx_timeout  output  1  one-cycle pulse when tx_busy failed to assert.

Behaviour:
- Reset: clocked on the clk edge while rst=1, so it is synchronous.
  - Clears state to IDLE, and clears tx_start, tx_data, grant_valid, grant_id, tx_timeout, the RR pointer, the lock flag and the timeout counter, all to 0.
  - req_ready=0 while rst=1.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, when not locked:
  - Eligible requesters are all i with req_valid[i]=1.
  - Pick the first eligible index searching from ptr upward, wrapping modulo NUM_REQ.
  - req_ready is combinational: req_ready[pick]=1 only in IDLE.
  - On a transfer (valid & ready), at the clock edge:
    - latch tx_data = req_data[pick];
    - grant_id = pick, grant_valid = 1;
    - lock = ~req_last[pick];
    - go to START.
- IDLE, when locked:
  - Only grant_id is eligible. Other requesters see ready=0 even if valid.
  - If the owner is not valid, wait indefinitely with no grant change.
- START:
  - tx_start=1 for exactly this one cycle.
  - Timeout counter cleared.
  - Go to WAIT_BUSY.
  - Latency: transfer edge at cycle T, tx_start high during T+1.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT-1:
    - pulse tx_timeout for 1 cycle;
    - clear lock and grant_valid;
    - set ptr = grant_id+1 (mod NUM_REQ);
    - go to IDLE. The packet is aborted.
  - tx_busy sampled high in the cycle after START counts as success.
- WAIT_DONE:
  - Wait for tx_busy=0. There is no timeout here; the transmitter guarantees frame completion.
  - On falling busy, go to IDLE.
  - If lock=0: grant_valid=0 and ptr = grant_id+1 (mod NUM_REQ), wrapping NUM_REQ-1 to 0.
  - If lock=1: grant and ptr are unchanged.
- Throughput: at most one byte per frame. The earliest next acceptance is the cycle after WAIT_DONE exits.
- Simultaneous requests: exactly one ready is asserted, never more than one. A requester that drops valid before being accepted loses no state.
- A packet whose last=1 arrives on its first byte is a single-byte packet: no lock.
- tx_data and grant_id are held until the next transfer, including through timeout.
- rst asserted in any state returns to IDLE on the next edge and drops tx_start that cycle. An in-flight frame is the transmitter's responsibility.

Decomposition:
- Package uart_pkg: state encoding constants (ST_IDLE..ST_WAIT_DONE), UART_DATA_W=8, CLKS_PER_BIT=521 (the shared baud constant).
- Sub-module uart_rr_pick: combinational masked round-robin picker.
  - Inputs: req vector, ptr, lock, lock_id.
  - Outputs: pick index, any_valid.
  - Reused by future RX-side arbitration.

Test Plan:
1. Single request: req_valid=0001, data 0x55, last=1.
   - ready[0] for 1 cycle, tx_start the next cycle, tx_data=0x55.
   - A busy model holding 10 bit-times returns IDLE; ptr=1.
2. All four valid simultaneously, each last=1, data 0xA0..0xA3.
   - Bytes go out in order 0,1,2,3, then 0 again.
   - Never more than one ready high.
3. Lock: req0 sends 3 bytes (last on the third) while req1 is valid throughout.
   - req1 is not granted until req0's third frame completes.
   - grant_valid stays high across all 3 frames.
4. Wrap: ptr=3 and req_valid=1001.
   - Grant 3, then 0.
   - ptr ends at 1.
5. Timeout: busy model never asserts.
   - tx_timeout pulses exactly BUSY_TIMEOUT cycles after tx_start.
   - Lock is cleared; the next requester is served.
6. Reset mid-frame in WAIT_DONE.
   - Next edge: all outputs 0, state IDLE.
   - A pending request is accepted after rst deasserts.
